// File: rtl/ncc_pkg.sv
// Shared types and width helpers for the NCC descriptor loader.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ncc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2
    } ncc_state_e;

    // Pixel counter must reach NUM_PIX inclusive.
    function automatic int ncc_cnt_w(input int num_pix);
        return $clog2(num_pix + 1);
    endfunction

    // Sum of NUM_PIX unsigned PIX_W values cannot exceed PIX_W + CNT_W bits.
    function automatic int ncc_sum_w(input int pix_w, input int num_pix);
        return pix_w + ncc_cnt_w(num_pix);
    endfunction

    // Sum of NUM_PIX squares cannot exceed 2*PIX_W + CNT_W bits.
    function automatic int ncc_sq_w(input int pix_w, input int num_pix);
        return 2 * pix_w + ncc_cnt_w(num_pix);
    endfunction

endpackage

// File: rtl/ncc_desc_shreg.sv
// Descriptor shift register: shifts left by one pixel per enabled cycle, newest pixel in the LSBs.
// Latency: one cycle from shift_i/clr_i to desc_o.
// Backpressure: none; caller gates shift_i. Ports: clk, rst, clr_i, shift_i, pix_i, desc_o.
module ncc_desc_shreg #(
    parameter int PIX_W   = 8,
    parameter int NUM_PIX = 256,
    localparam int DESC_W = PIX_W * NUM_PIX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              shift_i,
    input  logic [PIX_W-1:0]  pix_i,
    output logic [DESC_W-1:0] desc_o
);

    logic [DESC_W-1:0] desc_q;
    logic [DESC_W-1:0] desc_d;

    // Clear has priority so an abort coinciding with a pixel drops that pixel.
    always_comb begin
        desc_d = desc_q;
        if (clr_i) begin
            desc_d = '0;
        end else if (shift_i) begin
            desc_d = {desc_q[DESC_W-PIX_W-1:0], pix_i};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            desc_q <= '0;
        end else begin
            desc_q <= desc_d;
        end
    end

    assign desc_o = desc_q;

endmodule

// File: rtl/ncc_desc_loader.sv
// NCC descriptor loader: collects NUM_PIX pixels into a descriptor with running sum and sum of squares.
// Latency: desc_valid rises the cycle after the last accepted pixel; NUM_PIX cycles minimum per load.
// Backpressure: pix_ready only in LOAD; descriptor held in HOLD until desc_ack. Ports: start/abort control,
//               pix_in/pix_valid/pix_ready stream, desc_out/sum_out/sumsq_out/desc_valid/desc_ack result, busy.
module ncc_desc_loader
    import ncc_pkg::*;
#(
    parameter int PIX_W   = 8,
    parameter int NUM_PIX = 256,
    localparam int DESC_W = PIX_W * NUM_PIX,
    localparam int CNT_W  = ncc_cnt_w(NUM_PIX),
    localparam int SUM_W  = ncc_sum_w(PIX_W, NUM_PIX),
    localparam int SQ_W   = ncc_sq_w(PIX_W, NUM_PIX)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [PIX_W-1:0]  pix_in,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic [DESC_W-1:0] desc_out,
    output logic [SUM_W-1:0]  sum_out,
    output logic [SQ_W-1:0]   sumsq_out,
    output logic              desc_valid,
    input  logic              desc_ack,
    output logic              busy
);

    ncc_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [SQ_W-1:0]  sumsq_q, sumsq_d;
    logic             shreg_clr;
    logic             shreg_shift;

    // Square in a double-width domain so the product is not truncated.
    logic [2*PIX_W-1:0] pix_ext;
    logic [2*PIX_W-1:0] pix_sq;
    assign pix_ext = {{PIX_W{1'b0}}, pix_in};
    assign pix_sq  = pix_ext * pix_ext;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        sumsq_d     = sumsq_q;
        shreg_clr   = 1'b0;
        shreg_shift = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Abort alongside start cancels the start.
                if (start && !abort) begin
                    state_d   = ST_LOAD;
                    cnt_d     = '0;
                    sum_d     = '0;
                    sumsq_d   = '0;
                    shreg_clr = 1'b1;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    sum_d     = '0;
                    sumsq_d   = '0;
                    shreg_clr = 1'b1;
                end else if (pix_valid) begin
                    shreg_shift = 1'b1;
                    cnt_d       = cnt_q + CNT_W'(1);
                    sum_d       = sum_q + SUM_W'(pix_in);
                    sumsq_d     = sumsq_q + SQ_W'(pix_sq);
                    if (cnt_q == CNT_W'(NUM_PIX - 1)) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (desc_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sum_q   <= '0;
            sumsq_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            sumsq_q <= sumsq_d;
        end
    end

    ncc_desc_shreg #(
        .PIX_W   (PIX_W),
        .NUM_PIX (NUM_PIX)
    ) u_shreg (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (shreg_clr),
        .shift_i (shreg_shift),
        .pix_i   (pix_in),
        .desc_o  (desc_out)
    );

    // Handshake outputs are pure state decodes, so they drop with rst asynchronously.
    assign pix_ready  = (state_q == ST_LOAD);
    assign desc_valid = (state_q == ST_HOLD);
    assign busy       = (state_q != ST_IDLE);
    assign sum_out    = sum_q;
    assign sumsq_out  = sumsq_q;

endmodule

// File: tb/tb_ncc_desc_loader.sv
module tb_ncc_desc_loader;

    localparam int PIX_W   = 8;
    localparam int NUM_PIX = 4;
    localparam int DESC_W  = 32;
    localparam int SUM_W   = 11;
    localparam int SQ_W    = 19;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic [PIX_W-1:0]  pix_in;
    logic              pix_valid;
    logic              pix_ready;
    logic [DESC_W-1:0] desc_out;
    logic [SUM_W-1:0]  sum_out;
    logic [SQ_W-1:0]   sumsq_out;
    logic              desc_valid;
    logic              desc_ack;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;

    ncc_desc_loader #(
        .PIX_W   (PIX_W),
        .NUM_PIX (NUM_PIX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .desc_out   (desc_out),
        .sum_out    (sum_out),
        .sumsq_out  (sumsq_out),
        .desc_valid (desc_valid),
        .desc_ack   (desc_ack),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input logic [7:0] p);
        pix_valid = 1'b1;
        pix_in    = p;
        tick();
        pix_valid = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_desc"},  desc_out,   64'h0);
        chk({tag, "_sum"},   sum_out,    64'd0);
        chk({tag, "_sumsq"}, sumsq_out,  64'd0);
        chk({tag, "_dv"},    desc_valid, 64'd0);
        chk({tag, "_rdy"},   pix_ready,  64'd0);
        chk({tag, "_busy"},  busy,       64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; pix_in = '0; pix_valid = 1'b0; desc_ack = 1'b0;
        #2;
        chk_zero("reset");
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("idle_busy", busy, 64'd0);

        // Back-to-back 1,2,3,4.
        do_start();
        chk("t1_rdy", pix_ready, 64'd1);
        chk("t1_busy", busy, 64'd1);
        pix_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            pix_in = 8'(i);
            tick();
            if (i == 3) chk("t1_dv_early", desc_valid, 64'd0);
        end
        pix_valid = 1'b0;
        chk("t1_dv", desc_valid, 64'd1);
        chk("t1_rdy_hold", pix_ready, 64'd0);
        chk("t1_desc", desc_out, 64'h01020304);
        chk("t1_sum", sum_out, 64'd10);
        chk("t1_sumsq", sumsq_out, 64'd30);
        desc_ack = 1'b1;
        tick();
        desc_ack = 1'b0;
        chk("t1_dv_ack", desc_valid, 64'd0);
        chk("t1_busy_ack", busy, 64'd0);
        chk("t1_desc_retain", desc_out, 64'h01020304);
        chk("t1_sum_retain", sum_out, 64'd10);

        // 255 x4 with one idle cycle between beats; then 10-cycle HOLD.
        do_start();
        for (int i = 0; i < 4; i++) begin
            chk("t2_rdy", pix_ready, 64'd1);
            beat(8'd255);
            if (i < 3) begin
                chk("t2_rdy_bubble", pix_ready, 64'd1);
                chk("t2_dv_bubble", desc_valid, 64'd0);
                tick();
            end
        end
        chk("t2_dv", desc_valid, 64'd1);
        chk("t2_sum", sum_out, 64'd1020);
        chk("t2_sumsq", sumsq_out, 64'd260100);
        for (int i = 0; i < 10; i++) begin
            start     = i[0];
            pix_valid = ~i[0];
            pix_in    = 8'h11;
            tick();
            chk("t3_hold_desc", desc_out, 64'hFFFFFFFF);
            chk("t3_hold_sum", sum_out, 64'd1020);
            chk("t3_hold_rdy", pix_ready, 64'd0);
            chk("t3_hold_dv", desc_valid, 64'd1);
        end
        start = 1'b0; pix_valid = 1'b0;
        desc_ack = 1'b1;
        tick();
        desc_ack = 1'b0;
        chk("t3_dv_ack", desc_valid, 64'd0);

        // Abort together with the third pixel.
        do_start();
        beat(8'd1);
        beat(8'd2);
        abort = 1'b1;
        beat(8'd3);
        abort = 1'b0;
        chk_zero("t4_abort");
        // Start and abort in the same IDLE cycle stay in IDLE.
        abort = 1'b1;
        do_start();
        abort = 1'b0;
        chk("t4_startabort_busy", busy, 64'd0);
        tick();
        chk("t4_startabort_dv", desc_valid, 64'd0);
        do_start();
        for (int i = 5; i <= 8; i++) beat(8'(i));
        chk("t4_dv", desc_valid, 64'd1);
        chk("t4_desc", desc_out, 64'h05060708);
        chk("t4_sum", sum_out, 64'd26);
        chk("t4_sumsq", sumsq_out, 64'd174);
        desc_ack = 1'b1;
        tick();
        desc_ack = 1'b0;

        // Reset in the middle of a load.
        do_start();
        for (int i = 0; i < 3; i++) beat(8'd9);
        chk("t5_sum_pre", sum_out, 64'd27);
        rst = 1'b1;
        #1;
        chk_zero("t5_rst");
        tick();
        rst = 1'b0;
        tick(); tick();
        chk("t5_wait_busy", busy, 64'd0);
        do_start();
        for (int i = 0; i < 4; i++) beat(8'd9);
        chk("t5_dv", desc_valid, 64'd1);
        chk("t5_desc", desc_out, 64'h09090909);
        chk("t5_sum", sum_out, 64'd36);
        chk("t5_sumsq", sumsq_out, 64'd324);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ncc_desc_loader.md
NCC_DESC_LOADER -- requirements
Module: ncc_desc_loader

Interface
REQ-001 Parameter PIX_W, default 8, pixel width in bits.
REQ-002 Parameter NUM_PIX, default 256, pixels per descriptor; legal range 2..4096.
REQ-003 Derived widths: DESC_W=PIX_W*NUM_PIX; CNT_W=$clog2(NUM_PIX+1); SUM_W=PIX_W+CNT_W; SQ_W=2*PIX_W+CNT_W.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  begin a new descriptor load (IDLE only).
REQ-007 abort  in  1  cancel an in-progress load.
REQ-008 pix_in  in  PIX_W  unsigned pixel data.
REQ-009 pix_valid  in  1  pix_in carries a valid pixel.
REQ-010 pix_ready  out  1  block accepts a pixel this cycle.
REQ-011 desc_out  out  DESC_W  assembled descriptor.
REQ-012 sum_out  out  SUM_W  sum of all accepted pixels.
REQ-013 sumsq_out  out  SQ_W  sum of squares of all accepted pixels.
REQ-014 desc_valid  out  1  desc_out/sum_out/sumsq_out complete and stable.
REQ-015 desc_ack  in  1  consumer has taken the descriptor.
REQ-016 busy  out  1  high in LOAD and HOLD.

Function
REQ-017 FSM states: IDLE, LOAD, HOLD; all outputs registered or decoded from state only.
REQ-018 IDLE: start=1 and abort=0 -> clear shift register, pixel counter, sum, sumsq; go to LOAD next cycle.
REQ-019 LOAD: pix_ready=1; beat = pix_valid & pix_ready; per beat shift register shifts left by PIX_W with pix_in entering bits [PIX_W-1:0], counter +1, sum += pix_in, sumsq += pix_in*pix_in.
REQ-020 First accepted pixel ends in desc_out[DESC_W-1 -: PIX_W]; last in desc_out[PIX_W-1:0].
REQ-021 Counter width CNT_W; the beat taking count to NUM_PIX moves to HOLD next cycle; no further beats are accepted in that load.
REQ-022 Latency: last beat accepted in cycle N -> desc_valid=1 in cycle N+1; minimum load time NUM_PIX cycles with pix_valid held high.
REQ-023 pix_valid low in LOAD: no state change (bubbles allowed, unbounded).
REQ-024 HOLD: pix_ready=0, desc_valid=1, outputs constant; desc_ack=1 -> IDLE next cycle, desc_valid=0 from that cycle.
REQ-025 desc_out, sum_out, sumsq_out retain values in IDLE until next start.
REQ-026 abort=1 in LOAD -> IDLE next cycle, data/sums cleared, desc_valid never asserted; abort beats a simultaneous pixel beat (pixel dropped).
REQ-027 abort in HOLD or IDLE ignored; abort and start in same IDLE cycle -> remain IDLE.
REQ-028 start ignored in LOAD and HOLD.
REQ-029 sum/sumsq arithmetic unsigned, full width, no overflow possible by width rule REQ-003.

Reset
REQ-030 rst=1 -> state IDLE, pix_ready=0, desc_valid=0, busy=0, desc_out=0, sum_out=0, sumsq_out=0, counter=0, immediately and asynchronously.
REQ-031 Reset mid-LOAD or mid-HOLD discards all data; after release block waits for start.

Structure
REQ-032 Shared package ncc_pkg holds the state enum type and width helper functions for CNT_W, SUM_W, SQ_W.
REQ-033 One sub-module ncc_desc_shreg: parametrised PIX_W/NUM_PIX shift register with clear and shift-enable.
REQ-034 Counter, accumulators and FSM inline in ncc_desc_loader.

Verification (bench PIX_W=8, NUM_PIX=4)
REQ-035 start, pixels 1,2,3,4 back-to-back -> desc_out=32'h01020304, sum_out=10, sumsq_out=30, desc_valid one cycle after 4th beat.
REQ-036 Pixels 255x4 with one idle cycle between each -> sum_out=1020, sumsq_out=260100, no overflow, pix_ready high throughout LOAD.
REQ-037 start, 2 pixels, abort together with 3rd pixel -> IDLE, desc_valid stays 0; new load 5,6,7,8 -> desc_out=32'h05060708, sum_out=26.
REQ-038 HOLD held 10 cycles with start and pix_valid pulsed -> outputs unchanged, pix_ready=0; desc_ack -> desc_valid=0 next cycle.
REQ-039 rst asserted after 3rd pixel -> all outputs 0 in same cycle; after release, load 9,9,9,9 -> sum_out=36, sumsq_out=324.
